// File: rtl/iob_native_mem_slave_pkg.sv
// Shared types and helpers for the IOb native memory slave.
// Bus-width helpers let a top-level user size packed req/resp vectors.
package iob_native_mem_slave_pkg;

    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } memState_t;

    // Packed request is {valid, addr, wdata, wstrb}; response is {rdata, ready}.
    function automatic int reqWidth(input int addrW, input int dataW);
        return 1 + addrW + dataW + dataW / 8;
    endfunction

    function automatic int respWidth(input int dataW);
        return dataW + 1;
    endfunction

endpackage

// File: rtl/iob_native_mem_slave_ram_array.sv
// Byte-enable synchronous single-port RAM; no control logic, contents not reset.
module iob_native_ram_array #(
    parameter int MEM_ADDR_W = 10,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  en_i,
    input  logic [DATA_W/8-1:0]   we_i,
    input  logic [MEM_ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] mem [2**MEM_ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Writes commit byte-wise; the read register only loads on a pure read.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (we_i[i]) begin
                    mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
            if (we_i == '0) begin
                rdata_q <= mem[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/iob_native_mem_slave.sv
// IOb native bus responder: word-organised RAM answering each request with a
// one-cycle ready pulse LATENCY cycles after acceptance; back-to-back capable.
module iob_native_mem_slave
    import iob_native_mem_slave_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int LATENCY    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready
);

    localparam int CNT_W = $clog2(LATENCY + 1);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : gBadLatency
        $error("iob_native_mem_slave: LATENCY must be in 1..16");
    end

    memState_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdValid_q, rdValid_d;

    logic                  accept;
    logic                  inRange;
    logic                  isWrite;
    logic [MEM_ADDR_W-1:0] wordIdx;
    logic                  ramEn;
    logic [DATA_W/8-1:0]   ramWe;
    logic [DATA_W-1:0]     ramRdata;

    // A new request is taken when idle or in the ready cycle itself.
    assign accept  = valid && (state_q == ST_IDLE || state_q == ST_RESP);
    assign inRange = (addr >> (MEM_ADDR_W + 2)) == '0;
    assign isWrite = wstrb != '0;
    assign wordIdx = addr[MEM_ADDR_W+1:2];
    assign ramEn   = accept && inRange;
    assign ramWe   = (accept && inRange) ? wstrb : '0;

    iob_native_ram_array #(
        .MEM_ADDR_W(MEM_ADDR_W),
        .DATA_W    (DATA_W)
    ) u_ram (
        .clk    (clk),
        .en_i   (ramEn),
        .we_i   (ramWe),
        .addr_i (wordIdx),
        .wdata_i(wdata),
        .rdata_o(ramRdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rdValid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdValid_q <= rdValid_d;
        end
    end

    // Counter is loaded with LATENCY-1 and RESP is entered on the edge where it reads 1.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdValid_d = rdValid_q;
        unique case (state_q)
            ST_IDLE, ST_RESP: begin
                if (valid) begin
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (accept) begin
            rdValid_d = inRange && !isWrite;
        end
    end

    // Writes and out-of-range reads answer with zero data.
    assign rdata = rdValid_q ? ramRdata : '0;
    assign ready = (state_q == ST_RESP);

endmodule

// File: tb/tb_iob_native_mem_slave.sv
// Directed bench for iob_native_mem_slave at LATENCY 1, 3 and 4.
module tb_iob_native_mem_slave;

    logic        clk;
    logic        rst1, rst3, rst4;
    logic        valid1, valid3, valid4;
    logic [31:0] addr1, addr3, addr4;
    logic [31:0] wdata1, wdata3, wdata4;
    logic [3:0]  wstrb1, wstrb3, wstrb4;
    logic [31:0] rdata1, rdata3, rdata4;
    logic        ready1, ready3, ready4;

    int total = 0;
    int bad   = 0;

    iob_native_mem_slave #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst1), .valid(valid1), .addr(addr1), .wdata(wdata1),
        .wstrb(wstrb1), .rdata(rdata1), .ready(ready1)
    );

    iob_native_mem_slave #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .LATENCY(3)) dut3 (
        .clk(clk), .rst(rst3), .valid(valid3), .addr(addr3), .wdata(wdata3),
        .wstrb(wstrb3), .rdata(rdata3), .ready(ready3)
    );

    iob_native_mem_slave #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .LATENCY(4)) dut4 (
        .clk(clk), .rst(rst4), .valid(valid4), .addr(addr4), .wdata(wdata4),
        .wstrb(wstrb4), .rdata(rdata4), .ready(ready4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int which, input logic v, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] s);
        case (which)
            1: begin valid1 = v; addr1 = a; wdata1 = d; wstrb1 = s; end
            3: begin valid3 = v; addr3 = a; wdata3 = d; wstrb3 = s; end
            default: begin valid4 = v; addr4 = a; wdata4 = d; wstrb4 = s; end
        endcase
    endtask

    function automatic logic getReady(input int which);
        case (which)
            1:       return ready1;
            3:       return ready3;
            default: return ready4;
        endcase
    endfunction

    function automatic logic [31:0] getRdata(input int which);
        case (which)
            1:       return rdata1;
            3:       return rdata3;
            default: return rdata4;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction: ready must stay low for lat-1 cycles, pulse once, then drop.
    task automatic runTxn(input int which, input int lat, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [31:0] expRdata, input string tag);
        applyStimulus(which, 1'b1, a, d, s);
        step();
        applyStimulus(which, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int i = 1; i < lat; i++) begin
            checkOutput({tag, "-wait"}, {31'b0, getReady(which)}, 32'h0);
            step();
        end
        checkOutput({tag, "-ready"}, {31'b0, getReady(which)}, 32'h1);
        checkOutput({tag, "-rdata"}, getRdata(which), expRdata);
        step();
        checkOutput({tag, "-drop"}, {31'b0, getReady(which)}, 32'h0);
    endtask

    initial begin
        rst1 = 1'b1; rst3 = 1'b1; rst4 = 1'b1;
        applyStimulus(1, 1'b1, 32'h10, 32'h0, 4'h0);
        applyStimulus(3, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(4, 1'b0, 32'h0, 32'h0, 4'h0);

        // Reset held with a pending valid request
        #1;
        checkOutput("rst-ready", {31'b0, ready1}, 32'h0);
        checkOutput("rst-rdata", rdata1, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("rst-hold-ready", {31'b0, ready1}, 32'h0);
            checkOutput("rst-hold-rdata", rdata1, 32'h0);
        end
        rst1 = 1'b0; rst3 = 1'b0; rst4 = 1'b0;
        applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'h0);
        step();
        checkOutput("post-rst-ready", {31'b0, ready1}, 32'h0);
        checkOutput("post-rst-rdata", rdata1, 32'h0);

        // LATENCY=1 back-to-back write then read of the same word
        applyStimulus(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        step();
        checkOutput("b2b-wr-ready", {31'b0, ready1}, 32'h1);
        checkOutput("b2b-wr-rdata", rdata1, 32'h0);
        applyStimulus(1, 1'b1, 32'h10, 32'h0, 4'h0);
        step();
        checkOutput("b2b-rd-ready", {31'b0, ready1}, 32'h1);
        checkOutput("b2b-rd-rdata", rdata1, 32'hDEADBEEF);
        applyStimulus(1, 1'b0, 32'h0, 32'h0, 4'h0);
        step();
        checkOutput("b2b-drop", {31'b0, ready1}, 32'h0);

        // Partial byte strobes
        runTxn(1, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, "ps-wr-full");
        runTxn(1, 1, 32'h20, 32'hAABBCCDD, 4'h5, 32'h0, "ps-wr-part");
        runTxn(1, 1, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, "ps-rd");

        // Out-of-range requests are answered without touching memory
        runTxn(1, 1, 32'h0, 32'hCAFEF00D, 4'hF, 32'h0, "oor-wr-base");
        runTxn(1, 1, 32'h1000, 32'h12345678, 4'hF, 32'h0, "oor-wr");
        runTxn(1, 1, 32'h1000, 32'h0, 4'h0, 32'h0, "oor-rd");
        runTxn(1, 1, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D, "oor-rd-base");

        // LATENCY=3 with valid held and address changed mid-wait
        runTxn(3, 3, 32'h10, 32'h0BADCAFE, 4'hF, 32'h0, "l3-wr10");
        runTxn(3, 3, 32'h20, 32'h5555AAAA, 4'hF, 32'h0, "l3-wr20");
        applyStimulus(3, 1'b1, 32'h10, 32'h0, 4'h0);
        step();
        checkOutput("l3-hold-e0", {31'b0, ready3}, 32'h0);
        applyStimulus(3, 1'b1, 32'h20, 32'h0, 4'h0);
        step();
        checkOutput("l3-hold-e1", {31'b0, ready3}, 32'h0);
        step();
        checkOutput("l3-hold-ready", {31'b0, ready3}, 32'h1);
        checkOutput("l3-hold-rdata", rdata3, 32'h0BADCAFE);
        step();
        checkOutput("l3-single-pulse", {31'b0, ready3}, 32'h0);
        applyStimulus(3, 1'b0, 32'h0, 32'h0, 4'h0);
        step();
        checkOutput("l3-second-wait", {31'b0, ready3}, 32'h0);
        step();
        checkOutput("l3-second-ready", {31'b0, ready3}, 32'h1);
        checkOutput("l3-second-rdata", rdata3, 32'h5555AAAA);
        step();
        checkOutput("l3-second-drop", {31'b0, ready3}, 32'h0);

        // LATENCY=4 reset two cycles into a read
        runTxn(4, 4, 32'h10, 32'h77778888, 4'hF, 32'h0, "l4-wr");
        applyStimulus(4, 1'b1, 32'h10, 32'h0, 4'h0);
        step();
        applyStimulus(4, 1'b0, 32'h0, 32'h0, 4'h0);
        step();
        step();
        rst4 = 1'b1;
        #1;
        checkOutput("l4-midrst-ready", {31'b0, ready4}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            checkOutput("l4-midrst-hold", {31'b0, ready4}, 32'h0);
        end
        rst4 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checkOutput("l4-no-stale-ready", {31'b0, ready4}, 32'h0);
        end
        runTxn(4, 4, 32'h10, 32'h0, 4'h0, 32'h77778888, "l4-rd-after-rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
